// File: rtl/arm_exe_pkg.sv
// arm_exe_pkg: ALU opcodes, shifter types, forward selects and multiplier FSM states
package arm_exe_pkg;
    typedef enum logic [3:0] {
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001,
        CMD_MUL = 4'b1111
    } exe_cmd_e;
    typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11} shift_e;
    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_MUL = 2'b01, ST_DONE = 2'b10} mul_state_e;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;
endpackage

// File: rtl/exe_mul_iter.sv
// exe_mul_iter: shift-add multiplier retiring MUL_STEP multiplier bits per step, low W product bits kept
module exe_mul_iter #(
    parameter int W        = 32,
    parameter int MUL_STEP = 4
) (
    input  logic         clk,
    input  logic         rest,
    input  logic         start_i,
    input  logic         step_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] prod_o,
    output logic         last_o
);
    localparam int N  = W / MUL_STEP;
    localparam int CW = $clog2(N + 1);
    logic [W-1:0]  a_q, b_q, acc_q;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (step_i) begin
            acc_q <= acc_q + a_q * W'(b_q[MUL_STEP-1:0]);
            a_q   <= a_q << MUL_STEP;
            b_q   <= b_q >> MUL_STEP;
            cnt_q <= cnt_q + 1'b1;
        end
    end
    assign prod_o = acc_q;
    assign last_o = cnt_q == CW'(N - 1);
endmodule

// File: rtl/exe_stage_mc.sv
// exe_stage_mc: execute stage with forwarding, shifter, ALU/NZCV, branch target and multi-cycle MUL behind valid/ready
module exe_stage_mc
    import arm_exe_pkg::*;
#(
    parameter int W        = 32,
    parameter int MUL_STEP = 4
) (
    input  logic         clk,
    input  logic         rest,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         flush,
    input  logic [3:0]   exe_cmd,
    input  logic         mem_r_en,
    input  logic         mem_w_en,
    input  logic         wb_en,
    input  logic [3:0]   wb_dest,
    input  logic [W-1:0] pc,
    input  logic [W-1:0] val1,
    input  logic [W-1:0] rm,
    input  logic         imm,
    input  logic [11:0]  shift_operand,
    input  logic [23:0]  signed_imm,
    input  logic         carry_in,
    input  logic [1:0]   sel_src1,
    input  logic [1:0]   sel_src2,
    input  logic [W-1:0] fwd_mem,
    input  logic [W-1:0] fwd_wb,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] alu_res,
    output logic [W-1:0] val_rm_out,
    output logic [W-1:0] branch_addr,
    output logic [3:0]   status,
    output logic         mem_r_en_out,
    output logic         mem_w_en_out,
    output logic         wb_en_out,
    output logic [3:0]   wb_dest_out,
    output logic         busy
);
    function automatic logic [W-1:0] ror(input logic [W-1:0] x, input int unsigned n);
        logic [2*W-1:0] d;
        d = {x, x} >> (n % W);
        return d[W-1:0];
    endfunction

    mul_state_e   state_q;
    logic         out_valid_q, mr_q, mw_q, wb_q;
    logic [W-1:0] alu_q, val_rm_q, br_q;
    logic [3:0]   status_q, dest_q;
    logic [W-1:0] op1, rm_f, sh_val, asr, val2, op2, res, br, prod;
    logic [W:0]   sum;
    logic [4:0]   sh_amt;
    logic [3:0]   flags;
    logic         is_sub, arith, cin, ovf, accept, is_mul, mul_last;

    assign op1    = sel_src1 == SEL_MEM ? fwd_mem : sel_src1 == SEL_WB ? fwd_wb : val1;
    assign rm_f   = sel_src2 == SEL_MEM ? fwd_mem : sel_src2 == SEL_WB ? fwd_wb : rm;
    assign sh_amt = shift_operand[11:7];
    assign asr    = $signed(rm_f) >>> sh_amt;
    assign sh_val = shift_operand[6:5] == SH_LSL ? rm_f << sh_amt :
                    shift_operand[6:5] == SH_LSR ? rm_f >> sh_amt :
                    shift_operand[6:5] == SH_ASR ? asr : ror(rm_f, 32'(sh_amt));
    assign val2   = imm ? ror(W'(shift_operand[7:0]), 2 * shift_operand[11:8]) :
                    (mem_r_en || mem_w_en) ? W'(shift_operand) : sh_val;

    // subtraction is op1 + ~val2 + carry, so C is the ARM not-borrow
    assign is_sub = exe_cmd == CMD_SUB || exe_cmd == CMD_SBC;
    assign arith  = is_sub || exe_cmd == CMD_ADD || exe_cmd == CMD_ADC;
    assign op2    = is_sub ? ~val2 : val2;
    assign cin    = exe_cmd == CMD_SUB || ((exe_cmd == CMD_ADC || exe_cmd == CMD_SBC) && carry_in);
    assign sum    = {1'b0, op1} + {1'b0, op2} + {{W{1'b0}}, cin};
    assign ovf    = op1[W-1] == op2[W-1] && sum[W-1] != op1[W-1];

    always_comb begin
        res = '0;
        case (exe_cmd)
            CMD_MOV: res = val2;
            CMD_MVN: res = ~val2;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: res = sum[W-1:0];
            CMD_AND: res = op1 & val2;
            CMD_ORR: res = op1 | val2;
            CMD_EOR: res = op1 ^ val2;
            default: res = '0;
        endcase
    end

    assign flags    = {res[W-1], res == '0, arith ? sum[W] : carry_in, arith && ovf};
    assign br       = pc + (W'($signed(signed_imm)) << 2);
    assign is_mul   = exe_cmd == CMD_MUL;
    assign busy     = state_q != ST_IDLE;
    assign in_ready = !busy && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    exe_mul_iter #(.W(W), .MUL_STEP(MUL_STEP)) u_mul (
        .clk    (clk),
        .rest   (rest),
        .start_i(accept && is_mul),
        .step_i (state_q == ST_MUL),
        .a_i    (op1),
        .b_i    (val2),
        .prod_o (prod),
        .last_o (mul_last)
    );

    // a MUL parks its side-band outputs and C at acceptance; DONE fills in the product and N/Z
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            alu_q       <= '0;
            val_rm_q    <= '0;
            br_q        <= '0;
            status_q    <= '0;
            mr_q        <= 1'b0;
            mw_q        <= 1'b0;
            wb_q        <= 1'b0;
            dest_q      <= '0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (accept) begin
                    state_q     <= is_mul ? ST_MUL : ST_IDLE;
                    out_valid_q <= !is_mul;
                    alu_q       <= res;
                    val_rm_q    <= rm_f;
                    br_q        <= br;
                    status_q    <= flags;
                    mr_q        <= mem_r_en;
                    mw_q        <= mem_w_en;
                    wb_q        <= wb_en;
                    dest_q      <= wb_dest;
                end
                ST_MUL: if (mul_last) state_q <= ST_DONE;
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b1;
                    alu_q       <= prod;
                    status_q    <= {prod[W-1], prod == '0, status_q[1], 1'b0};
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign alu_res      = alu_q;
    assign val_rm_out   = val_rm_q;
    assign branch_addr  = br_q;
    assign status       = status_q;
    assign mem_r_en_out = mr_q;
    assign mem_w_en_out = mw_q;
    assign wb_en_out    = wb_q;
    assign wb_dest_out  = dest_q;
endmodule

// File: tb/tb_exe_stage_mc.sv
// tb_exe_stage_mc: directed and randomized checks of exe_stage_mc against a behavioural model
module tb_exe_stage_mc;
    localparam int W = 32, MUL_STEP = 4;

    logic        clk = 1'b0, rest = 1'b0;
    logic        in_valid, in_ready, flush, mem_r_en, mem_w_en, wb_en, imm, carry_in;
    logic [3:0]  exe_cmd, wb_dest;
    logic [31:0] pc, val1, rm, fwd_mem, fwd_wb;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm;
    logic [1:0]  sel_src1, sel_src2;
    logic        out_valid, out_ready, mem_r_en_out, mem_w_en_out, wb_en_out, busy;
    logic [31:0] alu_res, val_rm_out, branch_addr;
    logic [3:0]  status, wb_dest_out;

    typedef struct {
        logic [31:0] alu, vrm, br;
        logic [3:0]  st, dest;
        logic        mr, mw, wb;
    } res_t;

    res_t er, pend;
    logic ev;
    int   mul_left, n_checks = 0, n_fail = 0, cyc;

    exe_stage_mc #(.W(W), .MUL_STEP(MUL_STEP)) dut (
        .clk(clk), .rest(rest), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en),
        .wb_dest(wb_dest), .pc(pc), .val1(val1), .rm(rm), .imm(imm),
        .shift_operand(shift_operand), .signed_imm(signed_imm), .carry_in(carry_in),
        .sel_src1(sel_src1), .sel_src2(sel_src2), .fwd_mem(fwd_mem), .fwd_wb(fwd_wb),
        .out_valid(out_valid), .out_ready(out_ready), .alu_res(alu_res),
        .val_rm_out(val_rm_out), .branch_addr(branch_addr), .status(status),
        .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out), .wb_en_out(wb_en_out),
        .wb_dest_out(wb_dest_out), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        for (int i = 0; i < n; i++) x = {x[0], x[31:1]};
        return x;
    endfunction

    function automatic res_t model_calc();
        res_t        r;
        logic [31:0] a, m, b, res;
        logic [63:0] p;
        longint      sw;
        int          amt, k;
        logic        c, v;
        a   = sel_src1 == 2'b01 ? fwd_mem : sel_src1 == 2'b10 ? fwd_wb : val1;
        m   = sel_src2 == 2'b01 ? fwd_mem : sel_src2 == 2'b10 ? fwd_wb : rm;
        amt = int'(shift_operand[11:7]);
        if (imm) b = rotr({24'b0, shift_operand[7:0]}, 2 * int'(shift_operand[11:8]));
        else if (mem_r_en || mem_w_en) b = {20'b0, shift_operand};
        else if (shift_operand[6:5] == 2'b00) b = m << amt;
        else if (shift_operand[6:5] == 2'b01) b = m >> amt;
        else if (shift_operand[6:5] == 2'b10) b = $signed(m) >>> amt;
        else b = rotr(m, amt);
        c   = carry_in;
        v   = 1'b0;
        res = 32'b0;
        k   = exe_cmd == 4'h2 ? 0 : exe_cmd == 4'h4 ? 1 : int'(carry_in);
        case (exe_cmd)
            4'h1: res = b;
            4'h9: res = ~b;
            4'h2, 4'h3: begin
                p   = {32'b0, a} + {32'b0, b} + 64'(k);
                res = p[31:0];
                c   = p[32];
                sw  = longint'($signed(a)) + longint'($signed(b)) + k;
                v   = sw != longint'($signed(res));
            end
            4'h4, 4'h5: begin
                res = a - b - 32'(1 - k);
                c   = {32'b0, a} >= {32'b0, b} + 64'(1 - k);
                sw  = longint'($signed(a)) - longint'($signed(b)) - (1 - k);
                v   = sw != longint'($signed(res));
            end
            4'h6: res = a & b;
            4'h7: res = a | b;
            4'h8: res = a ^ b;
            4'hF: begin
                p   = {32'b0, a} * {32'b0, b};
                res = p[31:0];
            end
            default: res = 32'b0;
        endcase
        r.alu  = res;
        r.vrm  = m;
        r.br   = pc + 32'(longint'($signed(signed_imm)) * 4);
        r.st   = {res[31], res == 0, c, v};
        r.mr   = mem_r_en;
        r.mw   = mem_w_en;
        r.wb   = wb_en;
        r.dest = wb_dest;
        return r;
    endfunction

    function automatic logic m_ready();
        return mul_left == 0 && (!ev || out_ready);
    endfunction

    task automatic m_reset();
        ev       = 1'b0;
        mul_left = 0;
        er       = '{default: '0};
        pend     = '{default: '0};
    endtask

    task automatic compare_outputs();
        check("out_valid", out_valid, ev);
        check("busy", busy, mul_left > 0);
        if (ev) begin
            check("alu_res", alu_res, er.alu);
            check("val_rm_out", val_rm_out, er.vrm);
            check("branch_addr", branch_addr, er.br);
            check("status", status, er.st);
            check("ctrl", {mem_r_en_out, mem_w_en_out, wb_en_out, wb_dest_out}, {er.mr, er.mw, er.wb, er.dest});
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_out_valid"}, out_valid, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_alu_res"}, alu_res, 0);
        check({pfx, "_val_rm_out"}, val_rm_out, 0);
        check({pfx, "_branch_addr"}, branch_addr, 0);
        check({pfx, "_status"}, status, 0);
        check({pfx, "_ctrl"}, {mem_r_en_out, mem_w_en_out, wb_en_out, wb_dest_out}, 0);
    endtask

    // inputs are set during the low phase; the model advances on the same edge as the DUT
    task automatic step();
        logic acc;
        res_t r;
        #1;
        check("in_ready", in_ready, m_ready());
        acc = in_valid && m_ready() && !flush;
        r   = model_calc();
        @(posedge clk);
        if (flush) begin
            ev       = 1'b0;
            mul_left = 0;
        end else if (mul_left > 0) begin
            mul_left--;
            if (mul_left == 0) begin
                er = pend;
                ev = 1'b1;
            end
        end else begin
            if (ev && out_ready) ev = 1'b0;
            if (acc && exe_cmd == 4'hF) begin
                pend     = r;
                mul_left = W / MUL_STEP + 1;
            end else if (acc) begin
                er = r;
                ev = 1'b1;
            end
        end
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; out_ready = 1; exe_cmd = 0;
        mem_r_en = 0; mem_w_en = 0; wb_en = 0; wb_dest = 0;
        pc = 0; val1 = 0; rm = 0; imm = 0; shift_operand = 0; signed_imm = 0;
        carry_in = 0; sel_src1 = 0; sel_src2 = 0; fwd_mem = 0; fwd_wb = 0;
    endtask

    task automatic cmd(input logic [3:0] c, input logic [31:0] a, input logic [31:0] r);
        in_valid = 1;
        exe_cmd  = c;
        val1     = a;
        rm       = r;
    endtask

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h7fffffff;
            2: return 32'h80000000;
            3: return 32'hffffffff;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_inputs();
        in_valid      = $urandom_range(0, 9) < 7;
        flush         = $urandom_range(0, 39) == 0;
        out_ready     = $urandom_range(0, 9) < 7;
        exe_cmd       = 4'($urandom_range(0, 15));
        mem_r_en      = $urandom_range(0, 5) == 0;
        mem_w_en      = $urandom_range(0, 5) == 0;
        wb_en         = 1'($urandom);
        wb_dest       = 4'($urandom);
        pc            = $urandom;
        val1          = rv();
        rm            = rv();
        imm           = $urandom_range(0, 2) == 0;
        shift_operand = 12'($urandom);
        signed_imm    = 24'($urandom);
        carry_in      = 1'($urandom);
        sel_src1      = 2'($urandom);
        sel_src2      = 2'($urandom);
        fwd_mem       = rv();
        fwd_wb        = rv();
    endtask

    initial begin
        idle();
        m_reset();
        rest = 0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rest = 1;
        #1 check("reset_in_ready", in_ready, 1);

        idle(); cmd(4'h2, 32'h7fffffff, 32'h1);
        step();
        check("add_ovf_res", alu_res, 32'h80000000);
        check("add_ovf_nzcv", status, 4'b1001);

        idle(); cmd(4'h1, 0, 0);
        imm = 1; shift_operand = 12'h4FF; pc = 32'h100; signed_imm = 24'hFFFFFF;
        step();
        check("mov_imm_res", alu_res, 32'hFF000000);
        check("branch_neg", branch_addr, 32'hFC);

        idle(); cmd(4'hF, 7, 6);
        step();
        in_valid = 0;
        cyc = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            cyc++;
            step();
        end
        check("mul_busy_cycles", cyc, 9);
        check("mul_res", alu_res, 42);
        check("mul_valid", out_valid, 1);

        idle(); cmd(4'h4, 0, 10); sel_src1 = 2'b01; fwd_mem = 10;
        step();
        check("sub_res", alu_res, 0);
        check("sub_nzcv", status, 4'b0110);
        out_ready = 0; exe_cmd = 4'h2; rm = 5;
        repeat (3) begin
            step();
            check("stall_in_ready", in_ready, 0);
            check("stall_alu", alu_res, 0);
        end
        out_ready = 1;
        step();
        check("after_stall_add", alu_res, 15);

        idle(); cmd(4'hF, 3, 5);
        step();
        in_valid = 0;
        step();
        step();
        flush = 1;
        step();
        flush = 0;
        check("flush_busy", busy, 0);
        check("flush_valid", out_valid, 0);
        idle(); cmd(4'h2, 1, 1);
        step();
        check("post_flush_add", alu_res, 2);

        idle(); cmd(4'hF, 9, 9); pc = 32'h1234; wb_en = 1; wb_dest = 4'hA;
        step();
        in_valid = 0;
        step();
        #2 rest = 0;
        #1 check_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        idle();
        rest = 1;
        m_reset();
        #1 check("rst_release_in_ready", in_ready, 1);
        compare_outputs();

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
